// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Handshake bundle for the instruction encoder. The input side
//                carries one symbolic instruction, and the output side carries
//                the packed word, its address and the status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if;
    logic        clear;
    logic        inValid;
    logic        inReady;
    logic [3:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] target;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstr;
    logic [31:0] outAddr;
    logic [15:0] count;
    logic        errIllegal;
    logic        errRange;

    // Program source / IM writer side
    modport master (
        output clear, inValid, mnem, rs, rt, rd, imm, target, outReady,
        input  inReady, outValid, outInstr, outAddr, count, errIllegal, errRange
    );

    // Encoder side
    modport slave (
        input  clear, inValid, mnem, rs, rt, rd, imm, target, outReady,
        output inReady, outValid, outInstr, outAddr, count, errIllegal, errRange
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Streaming MIPS-subset instruction encoder. This module
//                accepts one symbolic instruction per handshake and emits the
//                packed 32-bit word together with its byte address through a
//                single output register stage.
//                Optional macro ENC_RANGE_CHECK_EN builds the branch/jump
//                target range checker that drives errRange.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    instr_encoder_if.slave bus
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_XORI  = 6'h0e;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;

    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_SLT   = 6'h2a;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_addr;
    logic [15:0] r_count;
    logic        r_err_illegal;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_xfer;
    logic        w_illegal;
    logic [31:0] w_pc_inc;
    logic [31:0] w_br_diff;
    logic signed [31:0] w_br_off;
    logic [31:0] w_word;
    logic        w_unused;

    // Single register stage: refill is allowed in the same cycle it drains.
    assign w_in_ready = !bus.clear && (!r_out_valid || bus.outReady);
    assign w_accept   = bus.inValid && w_in_ready;
    assign w_xfer     = r_out_valid && bus.outReady;
    assign w_illegal  = (bus.mnem >= 4'd12);

    // Branch offsets are relative to the delay-slot address, in words.
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_br_diff  = bus.target - w_pc_inc;
    assign w_br_off   = $signed(w_br_diff) >>> 2;

    // Pack the instruction fields for the presented mnemonic
    always_comb begin
        w_word = 32'h0;
        case (bus.mnem)
            4'd0:    w_word = {c_OP_RTYPE, bus.rs, bus.rt, bus.rd, 5'd0, c_FN_ADD};
            4'd1:    w_word = {c_OP_RTYPE, bus.rs, bus.rt, bus.rd, 5'd0, c_FN_SUB};
            4'd2:    w_word = {c_OP_RTYPE, bus.rs, bus.rt, bus.rd, 5'd0, c_FN_SLT};
            4'd3:    w_word = {c_OP_RTYPE, bus.rs, 5'd0, 5'd0, 5'd0, c_FN_JR};
            4'd4:    w_word = {c_OP_ADDI, bus.rs, bus.rt, bus.imm};
            4'd5:    w_word = {c_OP_XORI, bus.rs, bus.rt, bus.imm};
            4'd6:    w_word = {c_OP_LW,   bus.rs, bus.rt, bus.imm};
            4'd7:    w_word = {c_OP_SW,   bus.rs, bus.rt, bus.imm};
            4'd8:    w_word = {c_OP_BEQ,  bus.rs, bus.rt, w_br_off[15:0]};
            4'd9:    w_word = {c_OP_BNE,  bus.rs, bus.rt, w_br_off[15:0]};
            4'd10:   w_word = {c_OP_J,    bus.target[27:2]};
            4'd11:   w_word = {c_OP_JAL,  bus.target[27:2]};
            default: w_word = 32'h0;
        endcase
    end

    // Output stage, address counter, transfer counter and illegal flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= BASE_ADDR;
            r_out_valid   <= 1'b0;
            r_out_instr   <= 32'h0;
            r_out_addr    <= 32'h0;
            r_count       <= 16'h0;
            r_err_illegal <= 1'b0;
        end else if (bus.clear) begin
            r_pc          <= BASE_ADDR;
            r_out_valid   <= 1'b0;
            r_out_instr   <= 32'h0;
            r_out_addr    <= 32'h0;
            r_count       <= 16'h0;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_count <= r_count + 16'd1;
            end
            if (w_accept) begin
                r_out_instr <= w_word;
                r_out_addr  <= r_pc;
                r_out_valid <= 1'b1;
                r_pc        <= w_pc_inc;
                if (w_illegal) begin
                    r_err_illegal <= 1'b1;
                end
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ENC_RANGE_CHECK_EN
    logic r_err_range;
    logic w_is_branch;
    logic w_is_jump;
    logic w_br_fits;
    logic w_range_err;

    assign w_is_branch = (bus.mnem == 4'd8) || (bus.mnem == 4'd9);
    assign w_is_jump   = (bus.mnem == 4'd10) || (bus.mnem == 4'd11);
    // The offset fits 16 signed bits when bits 31..15 are all equal.
    assign w_br_fits   = (&w_br_off[31:15]) || !(|w_br_off[31:15]);
    assign w_range_err = (w_is_branch && ((bus.target[1:0] != 2'b00) || !w_br_fits)) ||
                         (w_is_jump   && ((bus.target[1:0] != 2'b00) ||
                                          (bus.target[31:28] != w_pc_inc[31:28])));

    // Sticky range flag, set by an accepted out-of-range branch or jump
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_range <= 1'b0;
        end else if (bus.clear) begin
            r_err_range <= 1'b0;
        end else if (w_accept && w_range_err) begin
            r_err_range <= 1'b1;
        end
    end

    assign bus.errRange = r_err_range;
    assign w_unused     = ^w_br_diff[1:0];
`else
    assign bus.errRange = 1'b0;
    assign w_unused     = ^{w_br_diff[1:0], w_br_off[31:16], bus.target[1:0], bus.target[31:28]};
`endif

    assign bus.inReady    = w_in_ready;
    assign bus.outValid   = r_out_valid;
    assign bus.outInstr   = r_out_instr;
    assign bus.outAddr    = r_out_addr;
    assign bus.count      = r_count;
    assign bus.errIllegal = r_err_illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder. It combines directed
//                program fragments with randomized traffic, and checks every
//                cycle against a behavioural model of the encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam longint      c_W  = 64'd4294967296;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    instr_encoder_if bus ();

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    longint      m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    longint      m_count;
    bit          m_ill;
    bit          m_rng;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint floor4(input longint d);
        longint r;
        r = ((d % 4) + 4) % 4;
        return (d - r) / 4;
    endfunction

    // Signed distance in words from the delay-slot address to the target.
    function automatic longint br_off(input longint tgt, input longint pc);
        longint d;
        d = (tgt - ((pc + 4) % c_W) + c_W) % c_W;
        if (d >= c_W / 2) d = d - c_W;
        return floor4(d);
    endfunction

    function automatic logic [31:0] ref_word(input longint m, input longint rs, input longint rt,
                                             input longint rd, input longint imm,
                                             input longint tgt, input longint pc);
        longint s26, s21, s16, s11, w, off;
        s26 = 64'd67108864; s21 = 64'd2097152; s16 = 64'd65536; s11 = 64'd2048;
        w = 0;
        case (m)
            0:  w = rs * s21 + rt * s16 + rd * s11 + 32;
            1:  w = rs * s21 + rt * s16 + rd * s11 + 34;
            2:  w = rs * s21 + rt * s16 + rd * s11 + 42;
            3:  w = rs * s21 + 8;
            4:  w = 8  * s26 + rs * s21 + rt * s16 + imm;
            5:  w = 14 * s26 + rs * s21 + rt * s16 + imm;
            6:  w = 35 * s26 + rs * s21 + rt * s16 + imm;
            7:  w = 43 * s26 + rs * s21 + rt * s16 + imm;
            8, 9: begin
                off = br_off(tgt, pc);
                w = (m == 8 ? 4 : 5) * s26 + rs * s21 + rt * s16 + ((off % 65536) + 65536) % 65536;
            end
            10, 11: w = (m == 10 ? 2 : 3) * s26 + (tgt / 4) % s26;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic bit ref_range(input longint m, input longint tgt, input longint pc);
        longint off;
        if (m == 8 || m == 9) begin
            off = br_off(tgt, pc);
            return (tgt % 4 != 0) || off < -32768 || off > 32767;
        end
        if (m == 10 || m == 11)
            return (tgt % 4 != 0) || (tgt / 268435456) != (((pc + 4) % c_W) / 268435456);
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pc = BASE; m_valid = 0; m_instr = 0; m_addr = 0; m_count = 0; m_ill = 0; m_rng = 0;
    endtask

    task automatic check_outs();
        chk("outValid", {31'd0, bus.outValid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("outInstr", bus.outInstr, m_instr);
            chk("outAddr", bus.outAddr, m_addr);
        end
        chk("count", {16'd0, bus.count}, m_count[31:0]);
        chk("errIllegal", {31'd0, bus.errIllegal}, {31'd0, m_ill});
        chk("errRange", {31'd0, bus.errRange}, {31'd0, m_rng});
    endtask

    // One clock cycle: drive at negedge, predict the edge, check at next negedge.
    task automatic step(input bit clr, input bit vld, input bit ordy, input longint m,
                        input longint rs, input longint rt, input longint rd,
                        input longint imm, input longint tgt);
        bit ready, acc, xfer;
        longint tg;
        tg = tgt % c_W;
        bus.clear = clr; bus.inValid = vld; bus.outReady = ordy;
        bus.mnem = m[3:0]; bus.rs = rs[4:0]; bus.rt = rt[4:0]; bus.rd = rd[4:0];
        bus.imm = imm[15:0]; bus.target = tg[31:0];
        #1;
        ready = !clr && (!m_valid || ordy);
        chk("inReady", {31'd0, bus.inReady}, {31'd0, ready});
        acc  = vld && ready;
        xfer = m_valid && ordy;
        if (clr) begin
            model_reset();
        end else begin
            if (xfer) m_count = (m_count + 1) % 65536;
            if (acc) begin
                m_instr = ref_word(m, rs, rt, rd, imm, tg, m_pc);
                m_addr  = m_pc[31:0];
                m_valid = 1;
                if (m >= 12) m_ill = 1;
`ifdef ENC_RANGE_CHECK_EN
                if (ref_range(m, tg, m_pc)) m_rng = 1;
`endif
                m_pc = (m_pc + 4) % c_W;
            end else if (xfer) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, ordy, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_clear();
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.clear = 0; bus.inValid = 0; bus.outReady = 0; bus.mnem = 0;
        bus.rs = 0; bus.rt = 0; bus.rd = 0; bus.imm = 0; bus.target = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs();
        chk("rst_instr", bus.outInstr, 32'h0);
        chk("rst_addr", bus.outAddr, 32'h0);
        reset = 1'b0;

        // ADD rd=3 rs=1 rt=2
        step(0, 1, 1, 0, 1, 2, 3, 0, 0);
        chk("add_word", bus.outInstr, 32'h0022_1820);
        idle(1);
        chk("add_count", {16'd0, bus.count}, 32'd1);

        // ADDI then LW back-to-back
        do_clear();
        step(0, 1, 1, 4, 0, 8, 0, 16'h0005, 0);
        chk("addi_word", bus.outInstr, 32'h2008_0005);
        step(0, 1, 1, 6, 8, 9, 0, 16'hFFFC, 0);
        chk("lw_word", bus.outInstr, 32'h8D09_FFFC);
        chk("lw_addr", bus.outAddr, 32'h4);

        // Branch / jump stream
        do_clear();
        step(0, 1, 1, 8, 1, 2, 0, 0, 32'hC);
        chk("beq_word", bus.outInstr, 32'h1022_0002);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 9, 1, 0, 0, 0, 32'h0);
        chk("bne_word", bus.outInstr, 32'h1420_FFFD);
        step(0, 1, 1, 11, 0, 0, 0, 0, 32'h0040_0010);
        chk("jal_word", bus.outInstr, 32'h0C10_0004);
        step(0, 1, 1, 3, 31, 7, 9, 0, 0);
        chk("jr_word", bus.outInstr, 32'h03E0_0008);

        // Backpressure for 3 cycles with input pending, then release
        repeat (3) step(0, 1, 0, 1, 4, 5, 6, 0, 0);
        repeat (3) step(0, 1, 1, 2, 7, 8, 9, 0, 0);
        idle(1);

        // Illegal mnemonic, then clear
        step(0, 1, 1, 13, 1, 1, 1, 1, 1);
        chk("ill_word", bus.outInstr, 32'h0);
        idle(1);
        idle(1);
        chk("ill_sticky", {31'd0, bus.errIllegal}, 32'd1);
        do_clear();
        step(0, 1, 1, 0, 1, 2, 3, 0, 0);
        chk("clr_addr", bus.outAddr, BASE);

        // Range boundary cases
        do_clear();
        step(0, 1, 1, 8, 0, 0, 0, 0, 32'h0004_0000);
        chk("beq_far_imm", {16'd0, bus.outInstr[15:0]}, 32'h0000_FFFF);
        do_clear();
        step(0, 1, 1, 10, 0, 0, 0, 0, 32'h0000_0006);
        do_clear();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            longint m, tg;
            bit clr;
            clr = ($urandom_range(0, 63) == 0);
            m = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0)
                tg = $urandom;
            else
                tg = (m_pc + 4 + 4 * (longint'($urandom_range(0, 400)) - 200) + c_W) % c_W;
            step(clr, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, m,
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 65535), tg);
        end

        // Reset asserted while output is stalled
        step(0, 1, 0, 4, 1, 2, 0, 16'h1234, 0);
        step(0, 1, 0, 4, 1, 2, 0, 16'h1234, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, bus.outValid}, 32'd0);
        chk("rst_async_count", {16'd0, bus.count}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 1, 5, 3, 4, 0, 16'h00FF, 0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
